parity_rx: RTL and testbench
============================

Name: parity_rx

Overview:
- Serial frame receiver and parity checker. It is the receive-side counterpart of the team's parity generator.
- Deserialises one frame from a single-bit line: 1 start bit, 8 data bits LSB-first, 1 parity bit, 1 stop bit.
- Recomputes parity under the selected parity type, compares it with the received parity bit, and flags mismatches.
- Sits between the line input pin and the byte-consumer logic.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit. Must be at least 4 and even.
- DATA_W, 8, data bits per frame. Fixed at 8; any other value is unsupported.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line. Idles high. Asynchronous to clk.
- parity_type  input  2  01 = odd, 10 = even, 00/11 = check disabled (parity bit is still sampled and discarded).
- data_out  output  8  last received byte. Held until the next frame completes.
- data_valid  output  1  one-cycle pulse when data_out updates.
- parity_err  output  1  one-cycle pulse coincident with data_valid when the parity check fails.
- framing_err  output  1  one-cycle pulse coincident with data_valid when the stop bit samples low.
- busy  output  1  high from confirmed start bit until return to IDLE.

Behaviour:
- Reset: asynchronous assert (reset = 0) forces every output to 0, state to IDLE, counters to 0, and both synchroniser flops to 1. Deassertion is used synchronously.
- Synchroniser: rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
- Counters:
  - clk_cnt counts 0..CLKS_PER_BIT-1.
  - bit_idx counts 0..7.
- States:
  - IDLE: when rx_s = 0, go to START and clear clk_cnt.
  - START: when clk_cnt = CLKS_PER_BIT/2-1, sample rx_s.
    - If 0: start bit confirmed. Latch parity_type into par_mode_q, set busy, clear clk_cnt and bit_idx, go to DATA.
    - If 1: false start. Return to IDLE with no outputs asserted.
  - DATA: at each clk_cnt = CLKS_PER_BIT-1 (mid-bit), shift rx_s into shreg[bit_idx] and increment bit_idx. After bit_idx 7 is sampled, go to PARITY.
  - PARITY: at mid-bit, latch par_rx = rx_s. Go to STOP.
  - STOP: at mid-bit, sample the stop bit.
    - Drive data_out = shreg and data_valid = 1 for exactly one cycle, via a DONE state.
    - parity_err = 1 when the check is enabled and par_rx ≠ expected. It is forced to 0 in modes 00/11.
    - framing_err = 1 when the stop bit sampled 0.
    - Go to DONE.
  - DONE: pulses are visible this cycle. Next cycle deassert busy and go to IDLE.
- Expected parity: odd mode expects ~^shreg; even mode expects ^shreg. This matches the generator: odd mode over 8'h00 expects 1.
- Latency: data_valid asserts exactly 1 clk after the stop-bit mid-sample.
- parity_type changes mid-frame are ignored; only par_mode_q is used.
- rx glitches during DATA/PARITY/STOP only matter if present at the sample point. There is no oversampling vote.
- If the stop bit samples low, the receiver still returns to IDLE. If rx_s is still 0, IDLE immediately begins a new START (a break condition produces repeated framing errors).
- Back-to-back frames: a start edge in the cycle after DONE is accepted.
- Reset mid-frame: the frame is abandoned silently. No pulse is emitted and data_out clears to 0.

Optional Feature:
- Macro: PARITY_RX_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt [7:0], a saturating count of parity_err pulses.
  - Saturates at 8'hFF.
  - Cleared only by reset.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package parity_pkg:
  - parity_type encodings: PAR_NONE = 2'b00, PAR_ODD = 2'b01, PAR_EVEN = 2'b10.
  - rx state enum (IDLE, START, DATA, PARITY, STOP, DONE).
  - Function exp_parity(data, mode), shared with the generator.
- One natural sub-module: parity_rx_sync (2-flop synchroniser, reset value 1).

Test Plan (CLKS_PER_BIT = 4):
- Hold reset = 0 while toggling rx -> all outputs 0 and busy = 0. Release reset and keep rx = 1 -> outputs stay 0.
- Odd mode, send 8'h00 with parity 1 and stop 1 -> data_out = 8'h00, data_valid pulses once, parity_err = 0. Same frame with parity 0 -> parity_err = 1.
- Even mode, send 8'h01 with parity 1 -> no error. Send 8'h03 with parity 1 -> parity_err = 1, data_out = 8'h03.
- Mode 00, send 8'hA5 with a deliberately wrong parity bit -> data_valid = 1, parity_err = 0. Stop bit = 0 -> framing_err = 1.
- Low pulse of 1 clk on rx in IDLE -> no busy, no data_valid (false start).
- Switch parity_type from 01 to 10 during the DATA state of 8'h07 (odd-correct parity 0) -> parity_err = 0. Then assert reset mid-frame -> no pulse and data_out = 0. With PARITY_RX_ERR_CNT_EN defined, send 300 bad frames -> err_cnt = 8'hFF.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator/receiver pair: parity-type
// encodings, receiver state enum, result payload and the expected-parity helper.
package parity_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_IDX_W = 3;
  localparam int unsigned ERR_CNT_W = 8;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } rx_state_e;

  // Outcome of one received frame as seen by the byte consumer
  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              parity_err;
    logic              framing_err;
  } rx_result_t;

  // Only the odd and even encodings enable the check; 00/11 discard the bit
  function automatic logic par_check_en(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

  // Parity bit the generator would have appended for this byte and mode
  function automatic logic exp_parity(input logic [BYTE_W-1:0] data,
                                      input logic [1:0]        mode);
    case (mode)
      PAR_ODD:  return ~^data;
      PAR_EVEN: return ^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/parity_rx_if.sv
// Line-side and consumer-side signals of the parity receiver.
// Optional macro PARITY_RX_ERR_CNT_EN adds the err_cnt output.
interface parity_rx_if;
  import parity_pkg::*;

  logic              rx;
  logic [1:0]        parity_type;
  logic [BYTE_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              framing_err;
  logic              busy;
`ifdef PARITY_RX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output rx, parity_type,
    input  data_out, data_valid, parity_err, framing_err, busy, err_cnt
  );

  modport slave (
    input  rx, parity_type,
    output data_out, data_valid, parity_err, framing_err, busy, err_cnt
  );
`else
  modport master (
    output rx, parity_type,
    input  data_out, data_valid, parity_err, framing_err, busy
  );

  modport slave (
    input  rx, parity_type,
    output data_out, data_valid, parity_err, framing_err, busy
  );
`endif

endinterface

// File: rtl/parity_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the
// idle-high level so reset release never looks like a start edge.
module parity_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_s_o
);

  logic meta_q;
  logic sync_q;

  // Metastability filter: two back-to-back flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
    end
  end

  assign rx_s_o = sync_q;

endmodule

// File: rtl/parity_rx.sv
// Serial frame receiver: 1 start, 8 data (LSB first), 1 parity, 1 stop bit.
// Recomputes parity under the mode latched at the start bit and reports
// parity/framing errors alongside a one-cycle data_valid pulse.
// Optional macro PARITY_RX_ERR_CNT_EN adds a saturating parity-error counter.
module parity_rx
  import parity_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  parity_rx_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  // Elaboration guards for unsupported configurations
  if (DATA_W != BYTE_W) begin : g_bad_data_w
    $error("parity_rx: DATA_W must be 8");
  end
  if ((CLKS_PER_BIT < 4) || ((CLKS_PER_BIT % 2) != 0)) begin : g_bad_cpb
    $error("parity_rx: CLKS_PER_BIT must be even and at least 4");
  end

  logic rx_s;

  rx_state_e            state_q,       state_d;
  logic [CNT_W-1:0]     clk_cnt_q,     clk_cnt_d;
  logic [BIT_IDX_W-1:0] bit_idx_q,     bit_idx_d;
  logic [BYTE_W-1:0]    shreg_q,       shreg_d;
  logic                 par_rx_q,      par_rx_d;
  logic [1:0]           par_mode_q,    par_mode_d;
  logic                 busy_q,        busy_d;
  logic [BYTE_W-1:0]    data_out_q,    data_out_d;
  logic                 data_valid_q,  data_valid_d;
  logic                 parity_err_q,  parity_err_d;
  logic                 framing_err_q, framing_err_d;
`ifdef PARITY_RX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q,     err_cnt_d;
`endif

  parity_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (reset),
    .rx_i   (bus.rx),
    .rx_s_o (rx_s)
  );

  // Next-state and output decode for the frame FSM
  always_comb begin
    state_d       = state_q;
    clk_cnt_d     = clk_cnt_q;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    par_rx_d      = par_rx_q;
    par_mode_d    = par_mode_q;
    busy_d        = busy_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    parity_err_d  = 1'b0;
    framing_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end

      START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            par_mode_d = bus.parity_type;
            busy_d     = 1'b1;
            bit_idx_d  = '0;
            state_d    = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d          = '0;
          shreg_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + BIT_IDX_W'(1);
          if (bit_idx_q == BIT_IDX_W'(BYTE_W - 1)) begin
            state_d = PARITY;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      PARITY: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          par_rx_d  = rx_s;
          state_d   = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d     = '0;
          data_out_d    = shreg_q;
          data_valid_d  = 1'b1;
          parity_err_d  = par_check_en(par_mode_q) &&
                          (par_rx_q != exp_parity(shreg_q, par_mode_q));
          framing_err_d = !rx_s;
          state_d       = DONE;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef PARITY_RX_ERR_CNT_EN
  // Saturating tally of parity errors, cleared only by reset
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (parity_err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end
`endif

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      clk_cnt_q     <= '0;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      par_rx_q      <= 1'b0;
      par_mode_q    <= PAR_NONE;
      busy_q        <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      par_rx_q      <= par_rx_d;
      par_mode_q    <= par_mode_d;
      busy_q        <= busy_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
    end
  end

`ifdef PARITY_RX_ERR_CNT_EN
  // Error counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.parity_err  = parity_err_q;
  assign bus.framing_err = framing_err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_parity_rx.sv
// Directed bench for parity_rx with a result scoreboard (CLKS_PER_BIT = 4).
module tb_parity_rx;
  import parity_pkg::*;

  localparam int unsigned CPB = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  parity_rx_if bus ();

  parity_rx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  rx_result_t exp_q[$];
  rx_result_t mon_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every data_valid pulse must match the oldest expected result
  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(bus.data_valid), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("data_out",    32'(bus.data_out),    32'(mon_exp.data));
        chk("parity_err",  32'(bus.parity_err),  32'(mon_exp.parity_err));
        chk("framing_err", 32'(bus.framing_err), 32'(mon_exp.framing_err));
      end
    end else if (bus.parity_err !== 1'b0 || bus.framing_err !== 1'b0) begin
      chk("stray_err_pulse", 32'({bus.parity_err, bus.framing_err}), 32'd0);
    end
  end

  // Drive one serial bit for CPB clocks, changing rx just after a rising edge
  task automatic drive_bit(input logic v);
    bus.rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input bit sw, input logic [1:0] sw_mode);
    @(posedge clk);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (sw && i == 3) bus.parity_type = sw_mode;
      drive_bit(d[i]);
    end
    drive_bit(par);
    drive_bit(stop);
    bus.rx = 1'b1;
  endtask

  // Send a frame, check pulse timing and that the scoreboard drained
  task automatic do_frame(input string tag, input logic [1:0] mode, input logic [7:0] d,
                          input logic par, input logic stop,
                          input logic e_perr, input logic e_ferr,
                          input bit sw, input logic [1:0] sw_mode);
    rx_result_t r;
    r.data        = d;
    r.parity_err  = e_perr;
    r.framing_err = e_ferr;
    bus.parity_type = mode;
    exp_q.push_back(r);
    send_frame(d, par, stop, sw, sw_mode);
    @(negedge clk);
    chk({tag, "_dv_early"}, 32'(bus.data_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_dv_latency"}, 32'(bus.data_valid), 32'd1);
    @(negedge clk);
    chk({tag, "_dv_single"}, 32'(bus.data_valid), 32'd0);
    chk({tag, "_busy_clear"}, 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    chk({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   pulses_before;
    logic busy_seen;

    // Reset held while the line toggles
    reset           = 1'b0;
    bus.rx          = 1'b1;
    bus.parity_type = PAR_NONE;
    repeat (6) begin
      @(negedge clk);
      bus.rx = ~bus.rx;
    end
    @(negedge clk);
    chk("rst_data_out",    32'(bus.data_out),    32'd0);
    chk("rst_data_valid",  32'(bus.data_valid),  32'd0);
    chk("rst_parity_err",  32'(bus.parity_err),  32'd0);
    chk("rst_framing_err", 32'(bus.framing_err), 32'd0);
    chk("rst_busy",        32'(bus.busy),        32'd0);
`ifdef PARITY_RX_ERR_CNT_EN
    chk("rst_err_cnt",     32'(bus.err_cnt),     32'd0);
`endif

    // Release with an idle line: nothing happens
    bus.rx = 1'b1;
    reset  = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy",   32'(bus.busy),     32'd0);
    chk("idle_pulses", 32'(n_pulses),     32'd0);
    chk("idle_data",   32'(bus.data_out), 32'd0);

    // Odd mode: 00 carries parity 1; parity 0 is an error
    do_frame("odd00_ok",  PAR_ODD, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, PAR_NONE);
    do_frame("odd00_bad", PAR_ODD, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, PAR_NONE);
    do_frame("oddFF_ok",  PAR_ODD, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, PAR_NONE);

    // Even mode: 01 carries parity 1; 03 with parity 1 is an error
    do_frame("even01_ok",  PAR_EVEN, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, PAR_NONE);
    do_frame("even03_bad", PAR_EVEN, 8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, PAR_NONE);
    do_frame("even80_ok",  PAR_EVEN, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, PAR_NONE);

    // Check disabled: a wrong parity bit is ignored; low stop bit is a framing error
    do_frame("none_A5",      PAR_NONE, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, PAR_NONE);
    do_frame("none_A5_stop0", 2'b11,   8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, PAR_NONE);
`ifdef PARITY_RX_ERR_CNT_EN
    chk("err_cnt_two", 32'(bus.err_cnt), 32'd2);
`endif

    // One-clock low glitch in IDLE is rejected as a false start
    pulses_before = n_pulses;
    busy_seen     = 1'b0;
    @(posedge clk);
    #1 bus.rx = 1'b0;
    @(posedge clk);
    #1 bus.rx = 1'b1;
    repeat (10) begin
      @(negedge clk);
      busy_seen = busy_seen | bus.busy;
    end
    chk("false_start_busy",   32'(busy_seen), 32'd0);
    chk("false_start_pulses", 32'(n_pulses),  32'(pulses_before));

    // Mode change mid-frame is ignored: 07 with odd-correct parity 0
    do_frame("mode_switch", PAR_ODD, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, PAR_EVEN);

    // Reset in the middle of a frame abandons it silently
    pulses_before   = n_pulses;
    bus.parity_type = PAR_EVEN;
    @(posedge clk);
    #1 bus.rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1 bus.rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    chk("midframe_busy",      32'(bus.busy),     32'd1);
    chk("midframe_data_hold", 32'(bus.data_out), 32'h07);
    reset = 1'b0;
    #1;
    chk("midreset_busy_async", 32'(bus.busy),     32'd0);
    chk("midreset_data_async", 32'(bus.data_out), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    chk("midreset_no_pulse", 32'(n_pulses),     32'(pulses_before));
    chk("midreset_data",     32'(bus.data_out), 32'd0);
    chk("midreset_busy",     32'(bus.busy),     32'd0);
`ifdef PARITY_RX_ERR_CNT_EN
    chk("midreset_err_cnt",  32'(bus.err_cnt),  32'd0);

    // Many bad frames: counter saturates at FF
    for (int i = 0; i < 300; i++) begin
      logic [7:0] d;
      d = 8'(i * 37 + 11);
      do_frame("sat_frame", PAR_EVEN, d, ~(^d), 1'b1, 1'b1, 1'b0, 1'b0, PAR_NONE);
      if (i == 253) chk("err_cnt_254", 32'(bus.err_cnt), 32'hFE);
    end
    chk("err_cnt_sat", 32'(bus.err_cnt), 32'hFF);
`endif

    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
